// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch (I)
// and data load/store (D). D has priority. After STARVE_LIMIT consecutive D
// grants made while I waits, the next grant goes to I. Every grant is
// followed by exactly one IDLE cycle before the next arbitration.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  // Instruction-fetch requester
  input  logic [31:0] i_addr,
  input  logic [3:0]  i_rmask,
  output logic [31:0] i_rdata,
  output logic        i_resp,
  // Data load/store requester
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_rmask,
  input  logic [3:0]  d_wmask,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_resp,
  // Shared memory port
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_rmask,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp,
  output logic        busy
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned MW = 4;
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [MW-1:0] mem_rmask_q, mem_rmask_d;
  logic [MW-1:0] mem_wmask_q, mem_wmask_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [SW-1:0] d_streak_q, d_streak_d;

  logic i_pend;
  logic d_pend;
  logic d_wins;

  // Request detection: any nonzero mask means the requester is waiting.
  assign i_pend = |i_rmask;
  assign d_pend = (|d_rmask) | (|d_wmask);

  // D wins unless I is waiting and D has already used up its streak.
  assign d_wins = d_pend & (~i_pend | (d_streak_q < STREAK_MAX));

  // State, shared-port and streak registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_addr_q  <= '0;
      mem_rmask_q <= '0;
      mem_wmask_q <= '0;
      mem_wdata_q <= '0;
      d_streak_q  <= '0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_rmask_q <= mem_rmask_d;
      mem_wmask_q <= mem_wmask_d;
      mem_wdata_q <= mem_wdata_d;
      d_streak_q  <= d_streak_d;
    end
  end

  // Arbitration in IDLE, hold-until-response in SERVE_*.
  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_rmask_d = mem_rmask_q;
    mem_wmask_d = mem_wmask_q;
    mem_wdata_d = mem_wdata_q;
    d_streak_d  = d_streak_q;

    unique case (state_q)
      IDLE: begin
        if (d_wins) begin
          state_d     = SERVE_D;
          mem_addr_d  = d_addr;
          mem_rmask_d = d_rmask;
          mem_wmask_d = d_wmask;
          mem_wdata_d = d_wdata;
          // Streak only grows while fetch is actually being held off.
          if (i_pend) begin
            if (d_streak_q != STREAK_MAX) begin
              d_streak_d = d_streak_q + SW'(1);
            end
          end else begin
            d_streak_d = '0;
          end
        end else if (i_pend) begin
          state_d     = SERVE_I;
          mem_addr_d  = i_addr;
          mem_rmask_d = i_rmask;
          mem_wmask_d = '0;
          mem_wdata_d = '0;
          d_streak_d  = '0;
        end
      end
      SERVE_I, SERVE_D: begin
        if (mem_resp) begin
          state_d     = IDLE;
          mem_rmask_d = '0;
          mem_wmask_d = '0;
        end
      end
      default: begin
        state_d     = IDLE;
        mem_rmask_d = '0;
        mem_wmask_d = '0;
      end
    endcase
  end

  // Responses and read data pass straight through to the current owner.
  assign i_resp  = mem_resp & (state_q == SERVE_I);
  assign d_resp  = mem_resp & (state_q == SERVE_D);
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

  assign mem_addr  = mem_addr_q;
  assign mem_rmask = mem_rmask_q;
  assign mem_wmask = mem_wmask_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios followed by random
// traffic, all checked against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;

  localparam int unsigned LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_addr;
  logic [3:0]  i_rmask;
  logic [31:0] i_rdata;
  logic        i_resp;
  logic [31:0] d_addr;
  logic [3:0]  d_rmask;
  logic [3:0]  d_wmask;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_resp;
  logic [31:0] mem_addr;
  logic [3:0]  mem_rmask;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;
  logic        busy;

  mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_rmask(i_rmask), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_addr(d_addr), .d_rmask(d_rmask), .d_wmask(d_wmask), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_addr(mem_addr), .mem_rmask(mem_rmask), .mem_wmask(mem_wmask),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Stimulus knobs (percent probabilities).
  int i_prob, d_prob, resp_prob, idle_resp_prob;
  bit rdata_fix;
  logic [31:0] rdata_val;

  // Requester bookkeeping.
  bit i_act, d_act;
  int i_done, d_done;
  logic [31:0] last_i_rdata, last_d_rdata;
  bit obs[$];   // observed response order from DUT: 1 = D, 0 = I

  // Transaction-level model of the shared port.
  bit          m_busy;
  bit          m_own;  // 1 = D owns the port
  int          m_streak;
  logic [31:0] exp_addr, exp_wdata;
  logic [3:0]  exp_rmask, exp_wmask;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_own = 0; m_streak = 0;
    exp_addr = '0; exp_wdata = '0; exp_rmask = '0; exp_wmask = '0;
  endtask

  // One clock cycle: drive, check combinational outputs, advance model, check registers.
  task automatic step();
    logic [31:0] r;
    int k;
    bit ip, dp;
    if (!i_act && $urandom_range(99) < i_prob) begin
      r = $urandom();
      i_addr  = {r[31:2], 2'b00};
      i_rmask = 4'($urandom_range(15, 1));
      i_act   = 1;
    end
    if (!i_act) i_rmask = '0;
    if (!d_act && $urandom_range(99) < d_prob) begin
      r = $urandom();
      d_addr  = {r[31:2], 2'b00};
      d_wdata = $urandom();
      k = $urandom_range(9);
      if (k < 4) begin
        d_rmask = 4'($urandom_range(15, 1)); d_wmask = '0;
      end else if (k < 9) begin
        d_rmask = '0; d_wmask = 4'($urandom_range(15, 1));
      end else begin
        d_rmask = 4'($urandom_range(15, 1)); d_wmask = 4'($urandom_range(15, 1));
      end
      d_act = 1;
    end
    if (!d_act) begin d_rmask = '0; d_wmask = '0; end
    mem_resp  = m_busy ? ($urandom_range(99) < resp_prob) : ($urandom_range(99) < idle_resp_prob);
    mem_rdata = rdata_fix ? rdata_val : $urandom();
    #1;
    check("i_resp", 32'(i_resp), 32'(mem_resp && m_busy && !m_own));
    check("d_resp", 32'(d_resp), 32'(mem_resp && m_busy && m_own));
    check("busy", 32'(busy), 32'(m_busy));
    if (i_resp) begin check("i_rdata", i_rdata, mem_rdata); last_i_rdata = i_rdata; obs.push_back(0); end
    if (d_resp) begin check("d_rdata", d_rdata, mem_rdata); last_d_rdata = d_rdata; obs.push_back(1); end
    if (m_busy) begin
      if (mem_resp) begin
        m_busy = 0; exp_rmask = '0; exp_wmask = '0;
        if (m_own) begin d_act = 0; d_done++; end
        else begin i_act = 0; i_done++; end
      end
    end else begin
      ip = i_act; dp = d_act;
      if (dp && (!ip || m_streak < int'(LIMIT))) begin
        m_busy = 1; m_own = 1;
        exp_addr = d_addr; exp_rmask = d_rmask; exp_wmask = d_wmask; exp_wdata = d_wdata;
        m_streak = ip ? ((m_streak + 1 > int'(LIMIT)) ? int'(LIMIT) : m_streak + 1) : 0;
      end else if (ip) begin
        m_busy = 1; m_own = 0;
        exp_addr = i_addr; exp_rmask = i_rmask; exp_wmask = '0; exp_wdata = '0;
        m_streak = 0;
      end
    end
    @(posedge clk); #1;
    check("mem_addr", mem_addr, exp_addr);
    check("mem_rmask", 32'(mem_rmask), 32'(exp_rmask));
    check("mem_wmask", 32'(mem_wmask), 32'(exp_wmask));
    check("mem_wdata", mem_wdata, exp_wdata);
  endtask

  bit exp4 [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

  initial begin
    int guard;
    int base;
    rst = 1'b1;
    i_addr = '0; i_rmask = '0; d_addr = '0; d_rmask = '0; d_wmask = '0; d_wdata = '0;
    mem_rdata = '0; mem_resp = 1'b0;
    i_prob = 0; d_prob = 0; resp_prob = 100; idle_resp_prob = 0;
    rdata_fix = 0; rdata_val = '0;
    i_act = 0; d_act = 0; i_done = 0; d_done = 0;
    last_i_rdata = '0; last_d_rdata = '0;
    model_reset();
    #13;
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_masks", 32'({mem_rmask, mem_wmask}), 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_resp", 32'({i_resp, d_resp}), 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Fetch-only read.
    rdata_fix = 1; rdata_val = 32'h0000_0013;
    i_addr = 32'h6000_0000; i_rmask = 4'hF; i_act = 1;
    step();
    check("t1_mem_rmask", 32'(mem_rmask), 32'hF);
    check("t1_mem_addr", mem_addr, 32'h6000_0000);
    guard = 0;
    while (i_done == 0 && guard < 20) begin step(); guard++; end
    check("t1_done", 32'(i_done), 32'd1);
    check("t1_i_rdata", last_i_rdata, 32'h0000_0013);
    step();
    check("t1_busy_after", 32'(busy), 32'h0);
    rdata_fix = 0;

    // Store.
    d_addr = 32'h6000_0100; d_wmask = 4'h3; d_rmask = 4'h0; d_wdata = 32'hDEAD_BEEF; d_act = 1;
    step();
    check("t2_mem_wmask", 32'(mem_wmask), 32'h3);
    check("t2_mem_rmask", 32'(mem_rmask), 32'h0);
    check("t2_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    guard = 0;
    while (d_done == 0 && guard < 20) begin step(); guard++; end
    check("t2_done", 32'(d_done), 32'd1);
    check("t2_no_i", 32'(i_done), 32'd1);

    // Simultaneous I and D: D first, then I.
    obs.delete();
    i_addr = 32'h6000_0040; i_rmask = 4'hF; i_act = 1;
    d_addr = 32'h6000_0200; d_rmask = 4'hF; d_wmask = 4'h0; d_act = 1;
    guard = 0;
    while (obs.size() < 2 && guard < 20) begin step(); guard++; end
    check("t3_count", 32'(obs.size()), 32'd2);
    if (obs.size() >= 2) begin
      check("t3_first_d", 32'(obs[0]), 32'd1);
      check("t3_second_i", 32'(obs[1]), 32'd0);
    end

    // Reset during SERVE_D, then stale mem_resp in IDLE.
    d_addr = 32'h6000_0300; d_rmask = 4'h0; d_wmask = 4'hF; d_wdata = 32'h1234_5678; d_act = 1;
    resp_prob = 0;
    step();
    check("t5_serving", 32'(busy), 32'h1);
    base = d_done;
    rst = 1'b1; mem_resp = 1'b1;
    #1;
    check("t5_masks_async", 32'({mem_rmask, mem_wmask}), 32'h0);
    check("t5_busy_async", 32'(busy), 32'h0);
    check("t5_d_resp", 32'(d_resp), 32'h0);
    model_reset();
    d_act = 0; i_act = 0;
    @(posedge clk); #2;
    rst = 1'b0;
    idle_resp_prob = 100; resp_prob = 100;
    step();
    step();
    check("t6_no_d_done", 32'(d_done), 32'(base));
    check("t6_idle", 32'(busy), 32'h0);
    idle_resp_prob = 0;

    // Starvation limit: I always pending, D re-requesting after every response.
    obs.delete();
    i_prob = 100; d_prob = 100; resp_prob = 100;
    guard = 0;
    while (obs.size() < 10 && guard < 100) begin step(); guard++; end
    check("t4_count", 32'(obs.size() >= 10), 32'd1);
    for (int k = 0; k < 10 && k < obs.size(); k++) check($sformatf("t4_order%0d", k), 32'(obs[k]), 32'(exp4[k]));

    // Random traffic.
    i_prob = 40; d_prob = 40; resp_prob = 35; idle_resp_prob = 20;
    for (int n = 0; n < 3000; n++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
